mips_mem_ctrl: RTL and testbench
================================

MIPS_MEM_CTRL -- requirements
Module: mips_mem_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SHALL be: WAIT_LIMIT, 255, maximum cycles to wait for ext_ack on one beat before timeout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 memread  input  1  processor word-read request.
REQ-006 memwrite  input  1  processor word-write request.
REQ-007 addr  input  32  processor byte address, word aligned.
REQ-008 writedata  input  32  processor write word.
REQ-009 memdata  output  32  registered read word returned to processor.
REQ-010 busy  output  1  transaction in progress; processor must hold request until done.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with done.
REQ-013 ext_addr  output  32  external byte address.
REQ-014 ext_re  output  1  external byte-read strobe.
REQ-015 ext_we  output  1  external byte-write strobe.
REQ-016 ext_wdata  output  8  external write byte.
REQ-017 ext_rdata  input  8  external read byte.
REQ-018 ext_ack  input  1  external beat acknowledge, sampled on clk.

Function
REQ-019 The FSM SHALL have states IDLE, XFER and DONE.
REQ-020 IDLE: busy=0, ext_re=ext_we=0.
REQ-021 IDLE: the block SHALL sample memread/memwrite each edge.
REQ-022 IDLE, valid request: latch addr, writedata and op; beat=0; go to XFER.
REQ-023 IDLE, memread and memwrite both high, or addr[1:0]!=0: no external access; go to DONE with err flagged.
REQ-024 XFER: busy=1; ext_addr={latched addr[31:2], beat[1:0]}.
REQ-025 XFER: ext_re=1 for read, ext_we=1 for write.
REQ-026 XFER: ext_wdata is big-endian; beat 0 = writedata[31:24] ... beat 3 = writedata[7:0].
REQ-027 XFER, ext_ack high at an edge: read captures ext_rdata into the big-endian lane for the current beat; beat increments; wait counter clears.
REQ-028 XFER, ack on beat 3: go to DONE.
REQ-029 XFER, ext_ack low at an edge: wait counter increments.
REQ-030 XFER, wait counter reaching WAIT_LIMIT: abort, go to DONE with err flagged.
REQ-031 Timeout: ext_re/ext_we deassert on entry to DONE.
REQ-032 DONE: done=1, busy=1, err as flagged, for exactly one cycle; then IDLE.
REQ-033 memdata SHALL update only on error-free read completion, visible in the DONE cycle; otherwise it holds.
REQ-034 Latency with ext_ack tied high: request sampled at edge E0; beats at E1..E4; done high between E4 and E5; IDLE from E5.
REQ-035 A request still asserted in the first IDLE cycle after DONE SHALL start a new transaction; the requester deasserts during done.
REQ-036 Request inputs SHALL be ignored outside IDLE; latched values only are used.

Reset
REQ-037 On reset assertion, state=IDLE and all outputs drop to 0 asynchronously, including mid-transaction strobes.
REQ-038 Zero values: memdata=0, ext_addr=0, ext_wdata=0, busy=done=err=ext_re=ext_we=0.
REQ-039 On reset, beat and wait counters SHALL clear, and partially assembled read data SHALL be discarded.

Structure
REQ-040 Package mips_mem_pkg SHALL hold the state enum (IDLE, XFER, DONE) and constant BEATS_PER_WORD=4.
REQ-041 One sub-module, mem_wait_timer, SHALL implement the per-beat timeout counter with clear, enable and expired ports.

Verification
REQ-042 Read, addr=0x00000010, ext_ack=1, ext_rdata 0x12,0x34,0x56,0x78 -> ext_addr 0x10..0x13, done at cycle 5, memdata=0x12345678, err=0.
REQ-043 Write, addr=0x00000020, writedata=0xCAFEBABE, ack delayed 2 cycles per beat -> ext_wdata CA,FE,BA,BE at 0x20..0x23, ext_we held each beat, done at cycle 13.
REQ-044 Read with addr=0x00000006 -> no ext_re ever, done=err=1 at cycle 1, memdata unchanged.
REQ-045 Read, WAIT_LIMIT=4, ext_ack never asserted -> err=done=1 after 4 wait cycles on beat 0, memdata unchanged, strobes low.
REQ-046 Reset asserted during beat 2 of a write -> ext_we and busy low immediately; after release, a read of 0x00000010 completes with correct data.
REQ-047 memread and memwrite both high -> err pulse, no external strobes.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS word-to-byte memory controller.
package mips_mem_pkg;

    // Number of byte beats needed to move one 32-bit word.
    localparam int unsigned BEATS_PER_WORD = 4;

    // Controller state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Beat index within a word (0 = most significant byte).
    typedef logic [1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(BEATS_PER_WORD - 1);

    // Big-endian lane extract: beat 0 is bits [31:24], beat 3 is bits [7:0].
    function automatic logic [7:0] get_lane(input logic [31:0] word, input beat_t beat);
        logic [7:0] lane;
        case (beat)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

    // Big-endian lane insert: returns word with the lane for beat replaced by data.
    function automatic logic [31:0] put_lane(input logic [31:0] word, input beat_t beat,
                                             input logic [7:0] data);
        logic [31:0] result;
        result = word;
        case (beat)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            default: result[7:0]   = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-beat wait counter: counts cycles without an acknowledge and flags the
// cycle whose count reaches WAIT_LIMIT.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] LAST_C  = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count enabled wait cycles, saturating at the limit.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first so no path infers a latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The wait cycle in progress is the one that brings the count up to WAIT_LIMIT.
    assign expired = enable && !clear && (count_q == LAST_C);

endmodule

// File: rtl/mips_mem_ctrl.sv
// Bridges single-word processor reads/writes onto a byte-wide acknowledged
// external bus, four big-endian beats per word, with a per-beat timeout.
module mips_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] memdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ext_addr,
    output logic        ext_re,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    state_e      state_q,     state_d;
    logic [29:0] word_addr_q, word_addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        is_write_q,  is_write_d;
    beat_t       beat_q,      beat_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [31:0] memdata_q,   memdata_d;
    logic        err_q,       err_d;

    logic req_any;
    logic req_bad;
    logic last_beat;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign req_any   = memread || memwrite;
    assign req_bad   = (memread && memwrite) || (addr[1:0] != 2'b00);
    assign last_beat = (beat_q == LAST_BEAT);

    // The wait count runs only while a beat is outstanding and restarts on every acknowledge.
    assign timer_en    = (state_q == XFER) && !ext_ack;
    assign timer_clear = (state_q != XFER) || ext_ack;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: bad requests skip straight to DONE, timeouts abort to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = req_bad ? DONE : XFER;
                end
            end
            XFER: begin
                if (ext_ack) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end else if (timer_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the request in IDLE, then walk the beats in XFER.
    always_comb begin
        word_addr_d = word_addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        beat_d      = beat_q;
        rdata_d     = rdata_q;
        memdata_d   = memdata_q;
        err_d       = err_q;

        if ((state_q == IDLE) && req_any) begin
            err_d = req_bad;
            if (!req_bad) begin
                word_addr_d = addr[31:2];
                wdata_d     = writedata;
                is_write_d  = memwrite;
                beat_d      = '0;
                rdata_d     = '0;
            end
        end

        if (state_q == XFER) begin
            if (ext_ack) begin
                beat_d = beat_q + 2'd1;
                if (!is_write_q) begin
                    rdata_d = put_lane(rdata_q, beat_q, ext_rdata);
                    // The assembled word reaches memdata on the same edge that enters DONE.
                    if (last_beat) begin
                        memdata_d = rdata_d;
                    end
                end
            end else if (timer_expired) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers; a reset also discards any partially assembled read word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_addr_q <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            beat_q      <= '0;
            rdata_q     <= '0;
            memdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            beat_q      <= beat_d;
            rdata_q     <= rdata_d;
            memdata_q   <= memdata_d;
            err_q       <= err_d;
        end
    end

    // Outputs decoded from the registered state, so they fall with reset immediately.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        ext_re    = 1'b0;
        ext_we    = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        case (state_q)
            XFER: begin
                busy      = 1'b1;
                ext_re    = !is_write_q;
                ext_we    = is_write_q;
                ext_addr  = {word_addr_q, beat_q};
                ext_wdata = get_lane(wdata_q, beat_q);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign memdata = memdata_q;

endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Self-checking bench for mips_mem_ctrl: directed cases plus randomized
// transactions checked against a transaction-level reference model.
module tb_mips_mem_ctrl;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] memdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ext_addr;
    logic        ext_re;
    logic        ext_we;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-beat plan: ack arrives after dly_tab[b] low cycles; byte_tab[b] is returned on that ack.
    int          dly_tab  [4];
    logic [7:0]  byte_tab [4];
    logic [31:0] exp_mem;

    mips_mem_ctrl #(
        .WAIT_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .memdata   (memdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ext_addr  (ext_addr),
        .ext_re    (ext_re),
        .ext_we    (ext_we),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly_tab[0] = d0;
        dly_tab[1] = d1;
        dly_tab[2] = d2;
        dly_tab[3] = d3;
    endtask

    task automatic set_bytes(input logic [31:0] w);
        byte_tab[0] = w[31:24];
        byte_tab[1] = w[23:16];
        byte_tab[2] = w[15:8];
        byte_tab[3] = w[7:0];
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_re"}, ext_re, 0);
        check({tag, "_we"}, ext_we, 0);
        check({tag, "_memdata"}, memdata, exp_mem);
    endtask

    // One processor transaction, started at a negedge while the DUT is idle.
    // Expected behaviour comes from the plan: each beat lasts dly+1 cycles, or
    // LIMIT cycles ending in an abort when dly reaches LIMIT.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        bit          bad;
        bit          timed_out;
        int          n;
        logic [7:0]  exp_byte;
        logic [31:0] exp_word;

        bad       = (rd && wr) || (a[1:0] != 2'b00);
        timed_out = 1'b0;
        exp_word  = {byte_tab[0], byte_tab[1], byte_tab[2], byte_tab[3]};

        memread   = rd;
        memwrite  = wr;
        addr      = a;
        writedata = wd;
        @(posedge clk);
        // Only the values latched at the request edge may matter from here on.
        #1;
        addr      = $urandom;
        writedata = $urandom;

        for (int b = 0; b < 4 && !bad && !timed_out; b++) begin
            n = (dly_tab[b] >= LIMIT) ? LIMIT : dly_tab[b] + 1;
            exp_byte = 8'(wd >> (8 * (3 - b)));
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                check("xfer_busy", busy, 1);
                check("xfer_done", done, 0);
                check("xfer_re", ext_re, rd);
                check("xfer_we", ext_we, wr);
                check("xfer_addr", ext_addr, {a[31:2], b[1:0]});
                if (wr) check("xfer_wdata", ext_wdata, exp_byte);
                ext_ack   = (i == dly_tab[b]);
                ext_rdata = ext_ack ? byte_tab[b] : 8'($urandom);
            end
            if (dly_tab[b] >= LIMIT) timed_out = 1'b1;
        end

        @(negedge clk);
        ext_ack = 1'b0;
        if (rd && !bad && !timed_out) exp_mem = exp_word;
        check("done_done", done, 1);
        check("done_busy", busy, 1);
        check("done_err", err, (bad || timed_out) ? 1 : 0);
        check("done_re", ext_re, 0);
        check("done_we", ext_we, 0);
        check("done_memdata", memdata, exp_mem);
        memread  = 1'b0;
        memwrite = 1'b0;

        @(negedge clk);
        check_idle("post");
    endtask

    initial begin
        bit          rd;
        bit          wr;
        int          op;
        logic [31:0] a;

        reset     = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        addr      = '0;
        writedata = '0;
        ext_rdata = '0;
        ext_ack   = 1'b0;
        exp_mem   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst_ext_addr", ext_addr, 0);
        check("rst_ext_wdata", {24'd0, ext_wdata}, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("rel");

        // Read, ack tied high.
        set_dly(0, 0, 0, 0);
        set_bytes(32'h12345678);
        run_txn(1, 0, 32'h0000_0010, 32'h0);

        // Write, two-cycle ack delay per beat.
        set_dly(2, 2, 2, 2);
        run_txn(0, 1, 32'h0000_0020, 32'hCAFE_BABE);

        // Longest delay that still completes.
        set_dly(LIMIT - 1, LIMIT - 1, LIMIT - 1, LIMIT - 1);
        set_bytes(32'hA5C3_0F96);
        run_txn(1, 0, 32'h0000_1004, 32'h0);

        // Misaligned read.
        run_txn(1, 0, 32'h0000_0006, 32'h0);

        // No acknowledge at all.
        set_dly(LIMIT + 5, 0, 0, 0);
        run_txn(1, 0, 32'h0000_0030, 32'h0);

        // Timeout on beat 2 of a read.
        set_dly(0, 1, LIMIT, 0);
        run_txn(1, 0, 32'h0000_0040, 32'h0);

        // Read and write together.
        set_dly(0, 0, 0, 0);
        run_txn(1, 1, 32'h0000_0050, 32'h1111_2222);

        // Reset during beat 2 of a write.
        set_dly(0, 0, 0, 0);
        memwrite  = 1'b1;
        addr      = 32'h0000_0040;
        writedata = 32'hDEAD_BEEF;
        ext_ack   = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("mid_we", ext_we, 1);
        check("mid_addr", ext_addr, 32'h0000_0042);
        reset = 1'b0;
        #1;
        exp_mem = '0;
        check("arst_we", ext_we, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", ext_addr, 0);
        check("arst_memdata", memdata, 0);
        memwrite = 1'b0;
        ext_ack  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_bytes(32'h1234_5678);
        run_txn(1, 0, 32'h0000_0010, 32'h0);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 15);
            rd = (op == 0) ? 1'b1 : op[0];
            wr = (op == 0) ? 1'b1 : !op[0];
            a  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            for (int b = 0; b < 4; b++) begin
                dly_tab[b]  = ($urandom_range(0, 11) == 0) ? LIMIT : $urandom_range(0, LIMIT - 1);
                byte_tab[b] = 8'($urandom);
            end
            run_txn(rd, wr, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
